// File: rtl/pc_seq_pkg.sv
// Shared definitions for the fetch-stage PC sequencer: next-PC command encodings.
package pc_seq_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_INC    = OP_W'(0);
    localparam logic [OP_W-1:0] OP_HOLD   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_BRANCH = OP_W'(2);
    localparam logic [OP_W-1:0] OP_JUMP   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_CALL   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_RET    = OP_W'(5);

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO: push writes at sp, top-of-stack read is combinational from sp-1.
module ret_stack #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] sp;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             do_push;
    logic             do_pop;

    assign empty   = (sp == '0);
    assign full    = (sp == PTR_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign wr_idx  = IDX_W'(sp);
    assign rd_idx  = IDX_W'(sp - PTR_W'(1));
    assign rdata   = mem[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= '0;
        end else if (do_push) begin
            sp <= sp + PTR_W'(1);
        end else if (do_pop) begin
            sp <= sp - PTR_W'(1);
        end
    end

    // Entries need no reset; only sp defines which are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= wdata;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: step/branch/jump/call/return with stall and sticky stack error flags.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned           PC_W      = 8,
    parameter int unsigned           STEP      = 1,
    parameter logic [PC_W-1:0]       RESET_VEC = '0,
    parameter int unsigned           STK_DEPTH = 4,
    parameter int unsigned           STK_PTR_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [OP_W-1:0] op,
    input  logic [PC_W-1:0] offset,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_seq,
    output logic            stk_empty,
    output logic            stk_full,
    output logic            stk_ovf,
    output logic            stk_unf
);

    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] stk_top;
    logic            push;
    logic            pop;
    logic            ovf_set;
    logic            unf_set;

    assign pc_seq = pc + PC_W'(STEP);

    ret_stack #(
        .W    (PC_W),
        .DEPTH(STK_DEPTH),
        .PTR_W(STK_PTR_W)
    ) u_stack (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .wdata(pc_seq),
        .rdata(stk_top),
        .empty(stk_empty),
        .full (stk_full)
    );

    // Next-PC selection; stall suppresses every state change including stack traffic.
    always_comb begin
        pc_next = pc;
        push    = 1'b0;
        pop     = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (!stall) begin
            case (op)
                OP_HOLD:   pc_next = pc;
                OP_BRANCH: pc_next = pc + offset;
                OP_JUMP:   pc_next = target;
                OP_CALL: begin
                    pc_next = target;
                    if (stk_full) begin
                        ovf_set = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
                OP_RET: begin
                    if (stk_empty) begin
                        pc_next = pc_seq;
                        unf_set = 1'b1;
                    end else begin
                        pc_next = stk_top;
                        pop     = 1'b1;
                    end
                end
                default:   pc_next = pc_seq;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_VEC;
            stk_ovf <= 1'b0;
            stk_unf <= 1'b0;
        end else begin
            pc <= pc_next;
            if (ovf_set) begin
                stk_ovf <= 1'b1;
            end
            if (unf_set) begin
                stk_unf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer (PC_W=8, STEP=1, RESET_VEC=0x10, depth 4).
module tb_pc_sequencer;

    localparam int unsigned PC_W = 8;

    typedef struct {
        logic       stall;
        logic [2:0] op;
        logic [7:0] off;
        logic [7:0] tgt;
        logic [7:0] pc;
        logic       empty;
        logic       full;
        logic       ovf;
        logic       unf;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            stall;
    logic [2:0]      op;
    logic [PC_W-1:0] offset;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_seq;
    logic            stk_empty;
    logic            stk_full;
    logic            stk_ovf;
    logic            stk_unf;

    int tests = 0;
    int fails = 0;

    vec_t vecs[$];

    pc_sequencer #(
        .PC_W     (PC_W),
        .STEP     (1),
        .RESET_VEC(8'h10),
        .STK_DEPTH(4),
        .STK_PTR_W(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .op       (op),
        .offset   (offset),
        .target   (target),
        .pc       (pc),
        .pc_seq   (pc_seq),
        .stk_empty(stk_empty),
        .stk_full (stk_full),
        .stk_ovf  (stk_ovf),
        .stk_unf  (stk_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [2:0] o, input logic [7:0] of, input logic [7:0] t);
        stall  = s;
        op     = o;
        offset = of;
        target = t;
    endtask

    task automatic chk_state(input string tag, input logic [7:0] epc, input logic e, input logic f,
                             input logic ov, input logic un);
        logic [7:0] eseq;
        eseq = epc + 8'd1;
        chk({tag, ".pc"}, 32'(pc), 32'(epc));
        chk({tag, ".pc_seq"}, 32'(pc_seq), 32'(eseq));
        chk({tag, ".empty"}, 32'(stk_empty), 32'(e));
        chk({tag, ".full"}, 32'(stk_full), 32'(f));
        chk({tag, ".ovf"}, 32'(stk_ovf), 32'(ov));
        chk({tag, ".unf"}, 32'(stk_unf), 32'(un));
    endtask

    function automatic vec_t v(input logic s, input logic [2:0] o, input logic [7:0] of, input logic [7:0] t,
                               input logic [7:0] p, input logic e, input logic f, input logic ov,
                               input logic un);
        vec_t r;
        r.stall = s; r.op = o; r.off = of; r.tgt = t;
        r.pc = p; r.empty = e; r.full = f; r.ovf = ov; r.unf = un;
        return r;
    endfunction

    initial begin
        // Ops: 0 INC, 1 HOLD, 2 BRANCH, 3 JUMP, 4 CALL, 5 RET.  Starting state pc=0x13, stack empty.
        vecs.push_back(v(0, 3'd3, 8'h00, 8'hFE, 8'hFE, 1, 0, 0, 0));
        vecs.push_back(v(0, 3'd0, 8'h00, 8'h00, 8'hFF, 1, 0, 0, 0));
        vecs.push_back(v(0, 3'd0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0));
        vecs.push_back(v(0, 3'd3, 8'h00, 8'h05, 8'h05, 1, 0, 0, 0));
        vecs.push_back(v(0, 3'd2, 8'hFB, 8'h00, 8'h00, 1, 0, 0, 0));
        vecs.push_back(v(0, 3'd3, 8'h00, 8'hF0, 8'hF0, 1, 0, 0, 0));
        vecs.push_back(v(0, 3'd2, 8'h20, 8'h00, 8'h10, 1, 0, 0, 0));
        vecs.push_back(v(0, 3'd2, 8'h00, 8'h00, 8'h10, 1, 0, 0, 0));
        vecs.push_back(v(0, 3'd1, 8'h00, 8'h77, 8'h10, 1, 0, 0, 0));
        // Stall against a pending JUMP.
        vecs.push_back(v(0, 3'd3, 8'h00, 8'h20, 8'h20, 1, 0, 0, 0));
        vecs.push_back(v(1, 3'd3, 8'h00, 8'h80, 8'h20, 1, 0, 0, 0));
        vecs.push_back(v(1, 3'd3, 8'h00, 8'h80, 8'h20, 1, 0, 0, 0));
        vecs.push_back(v(0, 3'd3, 8'h00, 8'h80, 8'h80, 1, 0, 0, 0));
        // Nested call/return, with a stalled RET in the middle.
        vecs.push_back(v(0, 3'd3, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0));
        vecs.push_back(v(0, 3'd4, 8'h00, 8'h40, 8'h40, 0, 0, 0, 0));
        vecs.push_back(v(0, 3'd4, 8'h00, 8'h60, 8'h60, 0, 0, 0, 0));
        vecs.push_back(v(0, 3'd0, 8'h00, 8'h00, 8'h61, 0, 0, 0, 0));
        vecs.push_back(v(1, 3'd5, 8'h00, 8'h00, 8'h61, 0, 0, 0, 0));
        vecs.push_back(v(0, 3'd5, 8'h00, 8'h00, 8'h41, 0, 0, 0, 0));
        vecs.push_back(v(0, 3'd5, 8'h00, 8'h00, 8'h01, 1, 0, 0, 0));
        vecs.push_back(v(0, 3'd6, 8'h00, 8'h00, 8'h02, 1, 0, 0, 0));
        vecs.push_back(v(0, 3'd7, 8'h00, 8'h00, 8'h03, 1, 0, 0, 0));
        // Overflow: fifth CALL while full jumps without pushing, so returns unwind the first four.
        vecs.push_back(v(0, 3'd3, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0));
        vecs.push_back(v(0, 3'd4, 8'h00, 8'h10, 8'h10, 0, 0, 0, 0));
        vecs.push_back(v(0, 3'd4, 8'h00, 8'h20, 8'h20, 0, 0, 0, 0));
        vecs.push_back(v(0, 3'd4, 8'h00, 8'h30, 8'h30, 0, 0, 0, 0));
        vecs.push_back(v(0, 3'd4, 8'h00, 8'h40, 8'h40, 0, 1, 0, 0));
        vecs.push_back(v(1, 3'd4, 8'h00, 8'h99, 8'h40, 0, 1, 0, 0));
        vecs.push_back(v(0, 3'd4, 8'h00, 8'h50, 8'h50, 0, 1, 1, 0));
        vecs.push_back(v(0, 3'd5, 8'h00, 8'h00, 8'h31, 0, 0, 1, 0));
        vecs.push_back(v(0, 3'd5, 8'h00, 8'h00, 8'h21, 0, 0, 1, 0));
        vecs.push_back(v(0, 3'd5, 8'h00, 8'h00, 8'h11, 0, 0, 1, 0));
        vecs.push_back(v(0, 3'd5, 8'h00, 8'h00, 8'h01, 1, 0, 1, 0));
        // Underflow from empty, then flags persist across later traffic.
        vecs.push_back(v(0, 3'd3, 8'h00, 8'h30, 8'h30, 1, 0, 1, 0));
        vecs.push_back(v(0, 3'd5, 8'h00, 8'h00, 8'h31, 1, 0, 1, 1));
        vecs.push_back(v(0, 3'd0, 8'h00, 8'h00, 8'h32, 1, 0, 1, 1));
        vecs.push_back(v(0, 3'd4, 8'h00, 8'h70, 8'h70, 0, 0, 1, 1));
        vecs.push_back(v(0, 3'd5, 8'h00, 8'h00, 8'h33, 1, 0, 1, 1));

        // Power-on reset.
        rst = 1'b1;
        drive(0, 3'd0, 8'h00, 8'h00);
        tick();
        tick();
        chk_state("reset", 8'h10, 1, 0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_state($sformatf("inc%0d", i), 8'(8'h11 + 8'(i)), 1, 0, 0, 0);
        end

        // Asynchronous reset mid-cycle with a JUMP pending: pc returns to the vector at once.
        drive(0, 3'd3, 8'h00, 8'hAA);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst.pc", 32'(pc), 32'h10);
        tick();
        chk("rst_held.pc", 32'(pc), 32'h10);
        rst = 1'b0;
        drive(0, 3'd0, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_state($sformatf("post_rst_inc%0d", i), 8'(8'h11 + 8'(i)), 1, 0, 0, 0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].stall, vecs[i].op, vecs[i].off, vecs[i].tgt);
            tick();
            chk_state($sformatf("vec%0d", i), vecs[i].pc, vecs[i].empty, vecs[i].full,
                      vecs[i].ovf, vecs[i].unf);
        end

        // pc_seq stays live while stalled.
        drive(1, 3'd3, 8'h00, 8'h00);
        tick();
        chk("stall_seq.pc_seq", 32'(pc_seq), 32'h34);

        // Only reset clears the sticky flags.
        rst = 1'b1;
        #1;
        chk_state("final_rst", 8'h10, 1, 0, 0, 0);
        tick();
        rst = 1'b0;
        drive(0, 3'd0, 8'h00, 8'h00);
        tick();
        chk_state("final_inc", 8'h11, 1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
